// File: rtl/oled_spi_tx.sv
// SPI mode-0 byte transmitter for an OLED panel, including the power-on reset pulse sequence.
// Define OLED_TX_FIFO_EN for a 4-entry input FIFO; otherwise a single holding register is used.
module oled_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int RES_CYCLES = 1000000
) (
  input  logic       CLK_100MHz,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       init_done,
  output logic       OLED_CLK,
  output logic       OLED_DIN,
  output logic       OLED_CS,
  output logic       OLED_D_C,
  output logic       OLED_RES
);

`ifdef OLED_TX_FIFO_EN
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`else
  localparam int DEPTH = 1;
  localparam int CW    = 1;
`endif
  localparam int RCW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
  localparam logic [RCW-1:0] RES_LAST  = RCW'(RES_CYCLES - 1);
  localparam logic [7:0]     HALF_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RES_LOW  = 3'd0,
    RES_WAIT = 3'd1,
    IDLE     = 3'd2,
    SHIFT    = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [RCW-1:0] r_rcnt, w_rcnt_nxt;
  logic [7:0]     r_half, w_half_nxt;
  logic [3:0]     r_phase, w_phase_nxt;
  logic [7:0]     r_sh, w_sh_nxt;
  logic           r_sclk, w_sclk_nxt;
  logic           r_cs, w_cs_nxt;
  logic           r_dc, w_dc_nxt;
  logic           r_res, w_res_nxt;
  logic           r_init, w_init_nxt;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_ready;
  logic           r_busy;
  logic           w_push;
  logic           w_pop;
  logic [8:0]     w_head;

  assign w_push = tx_valid & r_ready;

`ifdef OLED_TX_FIFO_EN
  logic [8:0] r_mem [0:3];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;

  // FIFO entry write; entries carry no reset because the pointers define validity
  always_ff @(posedge CLK_100MHz) begin
    if (w_push) begin
      r_mem[r_wptr] <= {tx_dc, tx_data};
    end
  end

  // FIFO read/write pointers
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
    end
  end

  assign w_head = r_mem[r_rptr];
`else
  logic [8:0] r_hold;

  // Single holding register for the next byte and its D/C flag
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_hold <= 9'd0;
    end else if (w_push) begin
      r_hold <= {tx_dc, tx_data};
    end
  end

  assign w_head = r_hold;
`endif

  // Storage occupancy after this cycle's push and pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state and next-pin logic for reset sequencing and serialisation
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_half_nxt  = r_half;
    w_phase_nxt = r_phase;
    w_sh_nxt    = r_sh;
    w_sclk_nxt  = r_sclk;
    w_cs_nxt    = r_cs;
    w_dc_nxt    = r_dc;
    w_res_nxt   = r_res;
    w_init_nxt  = r_init;
    w_pop       = 1'b0;
    case (r_state)
      RES_LOW: begin
        w_res_nxt = 1'b0;
        if (r_rcnt == RES_LAST) begin
          w_state_nxt = RES_WAIT;
          w_rcnt_nxt  = '0;
          w_res_nxt   = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + RCW'(1);
        end
      end
      RES_WAIT: begin
        w_res_nxt = 1'b1;
        if (r_rcnt == RES_LAST) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
          w_init_nxt  = 1'b1;
        end else begin
          w_rcnt_nxt = r_rcnt + RCW'(1);
        end
      end
      IDLE: begin
        w_cs_nxt   = 1'b1;
        w_sclk_nxt = 1'b0;
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
          w_sh_nxt    = w_head[7:0];
          w_dc_nxt    = w_head[8];
          w_cs_nxt    = 1'b0;
          w_half_nxt  = 8'd0;
          w_phase_nxt = 4'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        // Even phases are the low half of a bit, odd phases the high half
        if (r_half == HALF_LAST) begin
          w_half_nxt = 8'd0;
          if (r_phase == 4'd15) begin
            w_state_nxt = GAP;
            w_cs_nxt    = 1'b1;
            w_sclk_nxt  = 1'b0;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
            w_sclk_nxt  = ~r_phase[0];
            if (r_phase[0]) begin
              w_sh_nxt = {r_sh[6:0], 1'b0};
            end else begin
              w_sh_nxt = r_sh;
            end
          end
        end else begin
          w_half_nxt = r_half + 8'd1;
        end
      end
      GAP: begin
        if (r_half == HALF_LAST) begin
          w_half_nxt  = 8'd0;
          w_state_nxt = IDLE;
        end else begin
          w_half_nxt = r_half + 8'd1;
        end
      end
      default: begin
        w_state_nxt = RES_LOW;
        w_rcnt_nxt  = '0;
        w_res_nxt   = 1'b0;
        w_cs_nxt    = 1'b1;
        w_sclk_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_state <= RES_LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, pin and status registers
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      r_rcnt  <= '0;
      r_half  <= 8'd0;
      r_phase <= 4'd0;
      r_sh    <= 8'd0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_dc    <= 1'b0;
      r_res   <= 1'b0;
      r_init  <= 1'b0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_rcnt  <= w_rcnt_nxt;
      r_half  <= w_half_nxt;
      r_phase <= w_phase_nxt;
      r_sh    <= w_sh_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs    <= w_cs_nxt;
      r_dc    <= w_dc_nxt;
      r_res   <= w_res_nxt;
      r_init  <= w_init_nxt;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CW'(DEPTH));
      r_busy  <= (w_state_nxt == SHIFT) || (w_state_nxt == GAP) || (w_count_nxt != '0);
    end
  end

  assign tx_ready  = r_ready;
  assign busy      = r_busy;
  assign init_done = r_init;
  assign OLED_CLK  = r_sclk;
  assign OLED_DIN  = r_sh[7];
  assign OLED_CS   = r_cs;
  assign OLED_D_C  = r_dc;
  assign OLED_RES  = r_res;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed self-checking bench for oled_spi_tx with CLK_DIV=4 and RES_CYCLES=8.
module tb_oled_spi_tx;
  localparam int CLK_DIV    = 4;
  localparam int RES_CYCLES = 8;
`ifdef OLED_TX_FIFO_EN
  localparam int EXP_DEPTH = 4;
`else
  localparam int EXP_DEPTH = 1;
`endif

  logic       CLK_100MHz = 1'b0;
  logic       RST        = 1'b1;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_dc      = 1'b0;
  logic       tx_valid   = 1'b0;
  logic       tx_ready, busy, init_done;
  logic       OLED_CLK, OLED_DIN, OLED_CS, OLED_D_C, OLED_RES;

  oled_spi_tx #(.CLK_DIV(CLK_DIV), .RES_CYCLES(RES_CYCLES)) dut (
    .CLK_100MHz(CLK_100MHz), .RST(RST), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .init_done(init_done),
    .OLED_CLK(OLED_CLK), .OLED_DIN(OLED_DIN), .OLED_CS(OLED_CS),
    .OLED_D_C(OLED_D_C), .OLED_RES(OLED_RES)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  int checks = 0;
  int errors = 0;

  // Pin-level SPI receiver model, sampled on the falling system clock edge
  logic [8:0] rx_q[$];
  int   sclk_rises = 0, aborted = 0, cs_early = 0, din_viol = 0, dc_glitch = 0;
  int   low_len = 0, high_len = 0, last_low_len = 0, last_high_len = 0;
  int   cyc = 0, st_prev = 0, st_last = 0, bits = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_din = 1'b0, byte_dc = 1'b0;
  logic [7:0] acc = 8'h00;

  initial begin : monitor
    forever begin
      @(negedge CLK_100MHz);
      cyc++;
      if (OLED_CLK === 1'b1 && p_sclk === 1'b0) sclk_rises++;
      if (OLED_CLK === 1'b1 && p_sclk === 1'b1 && OLED_DIN !== p_din) din_viol++;
      if (OLED_CS === 1'b0) begin
        if (p_cs === 1'b1) begin
          bits = 0; acc = 8'h00; low_len = 0; byte_dc = OLED_D_C;
          last_high_len = high_len; st_prev = st_last; st_last = cyc;
          if (init_done !== 1'b1) cs_early++;
        end
        low_len++;
        if (OLED_D_C !== byte_dc) dc_glitch++;
        if (OLED_CLK === 1'b1 && p_sclk === 1'b0) begin
          acc = {acc[6:0], OLED_DIN};
          bits++;
        end
      end else begin
        if (p_cs === 1'b0) begin
          last_low_len = low_len;
          high_len = 0;
          if (bits == 8) rx_q.push_back({byte_dc, acc});
          else aborted++;
        end
        high_len++;
      end
      p_sclk = OLED_CLK; p_cs = OLED_CS; p_din = OLED_DIN;
    end
  end

  task automatic push(input logic [7:0] d, input logic c);
    int k;
    @(negedge CLK_100MHz);
    tx_data = d; tx_dc = c; tx_valid = 1'b1; k = 0;
    while (tx_ready !== 1'b1 && k < 3000) begin
      @(negedge CLK_100MHz);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL push_accept byte=%h: tx_ready stayed low for %0d cycles, required a slot", d, k);
    end
    @(negedge CLK_100MHz);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int lim);
    int k;
    k = 0;
    while (rx_q.size() < n && k < lim) begin
      @(negedge CLK_100MHz);
      k++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL rx_count got %0d bytes required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    int n, m;
    RST = 1'b1;
    @(posedge CLK_100MHz); #1;
    checks++;
    if ({OLED_RES, OLED_CS, OLED_CLK, OLED_DIN, OLED_D_C, init_done, busy, tx_ready} !== 8'b0100_0001) begin
      errors++;
      $display("FAIL reset_pins got %b required 01000001",
               {OLED_RES, OLED_CS, OLED_CLK, OLED_DIN, OLED_D_C, init_done, busy, tx_ready});
    end
    @(negedge CLK_100MHz);
    RST = 1'b0;
    n = 0;
    while (OLED_RES === 1'b0 && n < 100) begin n++; @(negedge CLK_100MHz); end
    m = 0;
    while (OLED_RES === 1'b1 && init_done === 1'b0 && m < 100) begin m++; @(negedge CLK_100MHz); end
    checks++;
    if (n != RES_CYCLES) begin errors++; $display("FAIL res_low_len got %0d required %0d", n, RES_CYCLES); end
    checks++;
    if (m != RES_CYCLES) begin errors++; $display("FAIL res_wait_len got %0d required %0d", m, RES_CYCLES); end
    checks++;
    if (init_done !== 1'b1 || OLED_RES !== 1'b1) begin
      errors++;
      $display("FAIL init_done got %b res %b required 1 1", init_done, OLED_RES);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || OLED_CS !== 1'b1) begin
      errors++;
      $display("FAIL idle_status got ready=%b busy=%b cs=%b required 1 0 1", tx_ready, busy, OLED_CS);
    end
  endtask

  task automatic test_single_cmd();
    int base;
    rx_q.delete();
    base = sclk_rises;
    push(8'hAE, 1'b0);
    wait_rx(1, 500);
    checks++;
    if (rx_q.size() < 1 || rx_q[0] !== 9'h0AE) begin
      errors++;
      $display("FAIL single_byte got %h required 0ae", (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
    end
    checks++;
    if (last_low_len != 16 * CLK_DIV) begin
      errors++;
      $display("FAIL single_cs_low got %0d cycles required %0d", last_low_len, 16 * CLK_DIV);
    end
    checks++;
    if (sclk_rises - base != 8) begin
      errors++;
      $display("FAIL single_sclk_rises got %0d required 8", sclk_rises - base);
    end
    repeat (8) @(negedge CLK_100MHz);
    checks++;
    if (busy !== 1'b0 || OLED_CS !== 1'b1 || OLED_CLK !== 1'b0) begin
      errors++;
      $display("FAIL single_after got busy=%b cs=%b clk=%b required 0 1 0", busy, OLED_CS, OLED_CLK);
    end
  endtask

  task automatic test_back_to_back();
    rx_q.delete();
    push(8'h81, 1'b1);
    push(8'h7F, 1'b1);
    wait_rx(2, 1000);
    checks++;
    if (rx_q.size() < 2 || rx_q[0] !== 9'h181 || rx_q[1] !== 9'h17F) begin
      errors++;
      $display("FAIL b2b_bytes got %h %h required 181 17f",
               (rx_q.size() > 0) ? rx_q[0] : 9'h000, (rx_q.size() > 1) ? rx_q[1] : 9'h000);
    end
    checks++;
    if (st_last - st_prev != 17 * CLK_DIV + 1) begin
      errors++;
      $display("FAIL b2b_period got %0d required %0d", st_last - st_prev, 17 * CLK_DIV + 1);
    end
    checks++;
    if (last_high_len != CLK_DIV + 1) begin
      errors++;
      $display("FAIL b2b_cs_high got %0d required %0d", last_high_len, CLK_DIV + 1);
    end
    checks++;
    if (last_low_len != 16 * CLK_DIV) begin
      errors++;
      $display("FAIL b2b_cs_low got %0d required %0d", last_low_len, 16 * CLK_DIV);
    end
  endtask

  task automatic test_early_push();
    int base;
    logic [8:0] exp_b [0:2];
    exp_b[0] = 9'h011; exp_b[1] = 9'h122; exp_b[2] = 9'h033;
    rx_q.delete();
    base = cs_early;
    RST = 1'b1;
    @(posedge CLK_100MHz);
    @(negedge CLK_100MHz);
    RST = 1'b0;
    push(8'h11, 1'b0);
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0 || OLED_RES !== 1'b0) begin
      errors++;
      $display("FAIL early_status got busy=%b init=%b res=%b required 1 0 0", busy, init_done, OLED_RES);
    end
    push(8'h22, 1'b1);
    push(8'h33, 1'b0);
    wait_rx(3, 2000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL early_byte%0d got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 9'h1FF, exp_b[i]);
      end
    end
    checks++;
    if (cs_early - base != 0) begin
      errors++;
      $display("FAIL early_cs got %0d CS falls before init required 0", cs_early - base);
    end
  endtask

  task automatic test_full_storage();
    int acc_n, k;
    logic [7:0] vals [0:7];
    vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    rx_q.delete();
    push(8'hA0, 1'b0);
    repeat (3) @(negedge CLK_100MHz);
    tx_data = vals[0]; tx_dc = 1'b0; tx_valid = 1'b1;
    acc_n = 0; k = 0;
    while (tx_ready === 1'b1 && k < 20) begin
      @(negedge CLK_100MHz);
      acc_n++;
      tx_data = vals[acc_n % 8];
      k++;
    end
    tx_valid = 1'b0;
    checks++;
    if (acc_n != EXP_DEPTH) begin
      errors++;
      $display("FAIL full_accepts got %0d required %0d", acc_n, EXP_DEPTH);
    end
    checks++;
    if (tx_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_status got ready=%b busy=%b required 0 1", tx_ready, busy);
    end
    wait_rx(1 + EXP_DEPTH, 3000);
    checks++;
    if (rx_q.size() < 1 || rx_q[0] !== 9'h0A0) begin
      errors++;
      $display("FAIL full_byte0 got %h required 0a0", (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
    end
    for (int i = 0; i < EXP_DEPTH; i++) begin
      checks++;
      if (rx_q.size() <= i + 1 || rx_q[i + 1] !== {1'b0, vals[i]}) begin
        errors++;
        $display("FAIL full_byte%0d got %h required %h", i + 1,
                 (rx_q.size() > i + 1) ? rx_q[i + 1] : 9'h1FF, {1'b0, vals[i]});
      end
    end
  endtask

  task automatic test_abort();
    int base_ab, r, k;
    logic p;
    rx_q.delete();
    base_ab = aborted;
    push(8'hC3, 1'b1);
    push(8'h5A, 1'b0);
    r = 0; k = 0; p = OLED_CLK;
    while (r < 3 && k < 500) begin
      @(negedge CLK_100MHz);
      if (OLED_CLK === 1'b1 && p === 1'b0) r++;
      p = OLED_CLK;
      k++;
    end
    checks++;
    if (r != 3) begin errors++; $display("FAIL abort_setup got %0d rises required 3", r); end
    RST = 1'b1;
    @(posedge CLK_100MHz); #1;
    checks++;
    if ({OLED_CS, OLED_RES, OLED_CLK, busy, tx_ready, init_done} !== 6'b100010) begin
      errors++;
      $display("FAIL abort_pins got cs,res,clk,busy,rdy,init=%b required 100010",
               {OLED_CS, OLED_RES, OLED_CLK, busy, tx_ready, init_done});
    end
    @(negedge CLK_100MHz);
    RST = 1'b0;
    r = 0; p = OLED_CLK;
    repeat (120) begin
      @(negedge CLK_100MHz);
      if (OLED_CLK === 1'b1 && p === 1'b0) r++;
      p = OLED_CLK;
    end
    checks++;
    if (r != 0) begin errors++; $display("FAIL abort_no_sclk got %0d rises required 0", r); end
    checks++;
    if (aborted - base_ab != 1 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL abort_bytes got aborted=%0d rx=%0d required 1 0", aborted - base_ab, rx_q.size());
    end
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover got init=%b busy=%b required 1 0", init_done, busy);
    end
  endtask

  task automatic test_pin_integrity();
    checks++;
    if (din_viol != 0) begin errors++; $display("FAIL din_while_high got %0d changes required 0", din_viol); end
    checks++;
    if (dc_glitch != 0) begin errors++; $display("FAIL dc_stable got %0d glitches required 0", dc_glitch); end
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_back_to_back();
    test_early_push();
    test_full_storage();
    test_abort();
    test_pin_integrity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
